// File: rtl/tohost_monitor.sv
// tohost_monitor: end-of-test detector snooping data-memory stores.
// Decodes pass/fail codes written to the tohost word, runs a cycle-count
// watchdog and holds a sticky verdict until reset.
// Optional feature macro: PC_LOOP_DETECT_EN (halt-loop detection on i_pc).
//
// state   | meaning
// RUN     | test running, counting cycles, decoding tohost stores
// PASS    | tohost wrote 1 (or halt loop detected); terminal
// FAIL    | tohost wrote an odd value other than 1; terminal
// TIMEOUT | watchdog expired in RUN; terminal
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FFC,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned LOOP_THRESH    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_Wd,
  input  logic        i_Wen,
  input  logic [31:0] i_pc,
  output logic        o_done,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout,
  output logic [30:0] o_code,
  output logic [31:0] o_cycles
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Last cycle value before the watchdog fires; the counter freezes here.
  localparam logic [31:0] LP_WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [30:0] r_code;
  logic [30:0] w_code_nxt;
  logic [31:0] r_cycles;

  logic w_hit;
  logic w_hit_pass;
  logic w_hit_fail;
  logic w_wdog;
  logic w_loop;

  assign w_hit      = i_Wen && (i_Addr[31:2] == TOHOST_ADDR[31:2]);
  assign w_hit_pass = w_hit && (i_Wd == 32'd1);
  assign w_hit_fail = w_hit && i_Wd[0] && (i_Wd != 32'd1);
  assign w_wdog     = (r_cycles == LP_WDOG_LAST);

`ifdef PC_LOOP_DETECT_EN
  localparam logic [31:0] LP_LOOP_LAST = 32'(LOOP_THRESH - 1);

  logic [31:0] r_prev_pc;
  logic [31:0] r_stable;
  logic        w_pc_same;

  assign w_pc_same = (i_pc == r_prev_pc);
  // This cycle is the LOOP_THRESH-th consecutive cycle with an unchanged PC.
  assign w_loop    = w_pc_same && (r_stable == LP_LOOP_LAST);

  // PC-stable counter: counts consecutive unchanged-PC cycles, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev_pc <= '0;
      r_stable  <= '0;
    end else begin
      r_prev_pc <= i_pc;
      if (!w_pc_same)
        r_stable <= '0;
      else if (r_stable != 32'hFFFF_FFFF)
        r_stable <= r_stable + 32'd1;
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^i_pc;
  assign w_loop      = 1'b0;
`endif

  // State, fail code and run-cycle counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_RUN;
      r_code   <= '0;
      r_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      // Count only cycles that stay in RUN so the value freezes at the verdict.
      if (r_state == ST_RUN && w_state_nxt == ST_RUN && r_cycles != 32'hFFFF_FFFF)
        r_cycles <= r_cycles + 32'd1;
    end
  end

  // Next-state decode: tohost store beats loop detect beats watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    if (r_state == ST_RUN) begin
      if (w_hit_pass) begin
        w_state_nxt = ST_PASS;
        w_code_nxt  = '0;
      end else if (w_hit_fail) begin
        w_state_nxt = ST_FAIL;
        w_code_nxt  = i_Wd[31:1];
      end else if (w_loop) begin
        w_state_nxt = ST_PASS;
        w_code_nxt  = '0;
      end else if (w_wdog) begin
        w_state_nxt = ST_TIMEOUT;
      end
    end
  end

  assign o_done    = (r_state != ST_RUN);
  assign o_pass    = (r_state == ST_PASS);
  assign o_fail    = (r_state == ST_FAIL);
  assign o_timeout = (r_state == ST_TIMEOUT);
  assign o_code    = r_code;
  assign o_cycles  = r_cycles;

endmodule
